// File: rtl/rv_exec_pipe_if.sv
// Instruction handshake and writeback/status bundle for rv_exec_pipe.
interface rv_exec_pipe_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned CNTW = 32
);
  logic [31:0]     inst;
  logic            inst_valid;
  logic            inst_ready;
  logic            hold;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            illegal;
  logic [CNTW-1:0] retired;

  // Instruction source / result consumer side
  modport master (
    output inst, inst_valid, hold,
    input  inst_ready, wb_valid, wb_rd, wb_data, illegal, retired
  );

  // Execution pipeline side
  modport slave (
    input  inst, inst_valid, hold,
    output inst_ready, wb_valid, wb_rd, wb_data, illegal, retired
  );
endinterface

// File: rtl/rv_exec_pipe.sv
// Two-stage (ID, EX) RV32I/RV64I OP / OP-IMM execution pipeline with
// EX-to-ID forwarding, illegal-instruction detection and a retire counter.
module rv_exec_pipe #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned CNTW = 32
) (
  input  logic          clk,
  input  logic          rst,
  rv_exec_pipe_if.slave bus
);
  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned RIW = $clog2(NREG);
  localparam logic [6:0]  OPC_OP  = 7'b0110011;
  localparam logic [6:0]  OPC_IMM = 7'b0010011;

  typedef struct packed {
    logic            valid;
    logic            ill;
    logic [2:0]      funct3;
    logic            alt;     // SUB / SRA / SRAI variant
    logic [4:0]      rd;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
  } idex_t;

  idex_t           idex_q, idex_d;
  logic [XLEN-1:0] rf_q [NREG];
  logic [XLEN-1:0] rf_d [NREG];
  logic            wb_valid_q, wb_valid_d;
  logic            illegal_q, illegal_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic [CNTW-1:0] retired_q, retired_d;

  logic [6:0]      opcode;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic            is_op, is_imm, legal, reg_ok;
  logic            shift_hi_zero, shift_hi_sra;
  logic            accept, fwd_en, retire;
  logic [XLEN-1:0] imm, rs1_val, rs2_val, ex_res;
  logic [SHW-1:0]  shamt;

  assign bus.inst_ready = !bus.hold;
  assign accept         = bus.inst_valid && !bus.hold;

  assign bus.wb_valid = wb_valid_q;
  assign bus.illegal  = illegal_q;
  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_data  = wb_data_q;
  assign bus.retired  = retired_q;

  // ID: field extraction and legality check
  always_comb begin
    opcode = bus.inst[6:0];
    rd     = bus.inst[11:7];
    funct3 = bus.inst[14:12];
    rs1    = bus.inst[19:15];
    rs2    = bus.inst[24:20];
    funct7 = bus.inst[31:25];
    is_op  = (opcode == OPC_OP);
    is_imm = (opcode == OPC_IMM);
    imm    = {{(XLEN-12){bus.inst[31]}}, bus.inst[31:20]};

    // Immediate shifts: the bits above the shift amount must be zero, or the SRAI pattern
    shift_hi_zero = (XLEN == 64) ? (bus.inst[31:26] == 6'b000000)
                                 : (bus.inst[31:25] == 7'b0000000);
    shift_hi_sra  = (XLEN == 64) ? (bus.inst[31:26] == 6'b010000)
                                 : (bus.inst[31:25] == 7'b0100000);

    reg_ok = (6'(rd) < 6'(NREG)) && (6'(rs1) < 6'(NREG)) &&
             (!is_op || (6'(rs2) < 6'(NREG)));

    legal = 1'b0;
    if (is_op) begin
      legal = (funct7 == 7'b0000000) ||
              ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
    end else if (is_imm) begin
      legal = 1'b1;
      if (funct3 == 3'b001) begin
        legal = shift_hi_zero;
      end else if (funct3 == 3'b101) begin
        legal = shift_hi_zero || shift_hi_sra;
      end
    end
    if (!reg_ok) begin
      legal = 1'b0;
    end
  end

  // ID: register read with independent EX-to-ID forwarding per source
  always_comb begin
    fwd_en  = idex_q.valid && !idex_q.ill && (idex_q.rd != 5'd0);
    rs1_val = (fwd_en && (idex_q.rd == rs1)) ? ex_res : rf_q[rs1[RIW-1:0]];
    rs2_val = (fwd_en && (idex_q.rd == rs2)) ? ex_res : rf_q[rs2[RIW-1:0]];

    idex_d        = '0;
    idex_d.valid  = accept;
    idex_d.ill    = !legal;
    idex_d.funct3 = funct3;
    idex_d.alt    = is_op ? bus.inst[30] : ((funct3 == 3'b101) && bus.inst[30]);
    idex_d.rd     = rd;
    idex_d.a      = rs1_val;
    idex_d.b      = is_op ? rs2_val : imm;
  end

  // EX: ALU
  always_comb begin
    shamt  = idex_q.b[SHW-1:0];
    ex_res = '0;
    case (idex_q.funct3)
      3'b000:  ex_res = idex_q.alt ? (idex_q.a - idex_q.b) : (idex_q.a + idex_q.b);
      3'b001:  ex_res = idex_q.a << shamt;
      3'b010:  ex_res = XLEN'($signed(idex_q.a) < $signed(idex_q.b));
      3'b011:  ex_res = XLEN'(idex_q.a < idex_q.b);
      3'b100:  ex_res = idex_q.a ^ idex_q.b;
      3'b101:  ex_res = idex_q.alt ? XLEN'($signed(idex_q.a) >>> shamt) : (idex_q.a >> shamt);
      3'b110:  ex_res = idex_q.a | idex_q.b;
      default: ex_res = idex_q.a & idex_q.b;
    endcase
  end

  // EX: register-file write, writeback outputs and retire counter
  always_comb begin
    retire = idex_q.valid && !idex_q.ill;
    rf_d   = rf_q;
    if (retire && (idex_q.rd != 5'd0)) begin
      rf_d[idex_q.rd[RIW-1:0]] = ex_res;
    end
    wb_valid_d = retire;
    illegal_d  = idex_q.valid && idex_q.ill;
    wb_rd_d    = retire ? idex_q.rd : wb_rd_q;
    wb_data_d  = wb_data_q;
    if (retire) begin
      wb_data_d = (idex_q.rd == 5'd0) ? '0 : ex_res;
    end
    retired_d = retired_q + CNTW'(retire);
  end

  // State registers; reset discards anything in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q     <= '0;
      rf_q       <= '{default: '0};
      wb_valid_q <= 1'b0;
      illegal_q  <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= '0;
      retired_q  <= '0;
    end else begin
      idex_q     <= idex_d;
      rf_q       <= rf_d;
      wb_valid_q <= wb_valid_d;
      illegal_q  <= illegal_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      retired_q  <= retired_d;
    end
  end
endmodule

// File: tb/tb_rv_exec_pipe.sv
// Scoreboard bench for rv_exec_pipe: one 32-bit/32-reg instance and one
// 64-bit/16-reg instance (4-bit retire counter) share a single stimulus stream.
module tb_rv_exec_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst_r = 32'h0;
  logic        valid_r = 1'b0;
  logic        hold_r = 1'b0;
  logic [31:0] cyc = 32'd0;

  rv_exec_pipe_if #(.XLEN(32), .CNTW(32)) bus32 ();
  rv_exec_pipe_if #(.XLEN(64), .CNTW(4))  bus64 ();

  assign bus32.inst = inst_r;
  assign bus32.inst_valid = valid_r;
  assign bus32.hold = hold_r;
  assign bus64.inst = inst_r;
  assign bus64.inst_valid = valid_r;
  assign bus64.hold = hold_r;

  rv_exec_pipe #(.XLEN(32), .NREG(32), .CNTW(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  rv_exec_pipe #(.XLEN(64), .NREG(16), .CNTW(4))  dut64 (.clk(clk), .rst(rst), .bus(bus64));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;

  typedef struct packed {
    logic        ill;
    logic [4:0]  rd;
    logic [63:0] data;
    logic [31:0] cyc;
  } exp_t;

  exp_t        q32[$];
  exp_t        q64[$];
  logic [63:0] rf32 [32];
  logic [63:0] rf64 [16];
  logic [63:0] ret32 = 64'd0;
  logic [63:0] ret64 = 64'd0;
  int          total = 0;
  int          passed = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [63:0] sx(input logic [63:0] v, input int xl);
    return (xl == 32) ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  // Architectural reference: result of one instruction from its source values
  function automatic void ref_exec(input int xl, input int nr, input logic [31:0] in,
                                   input logic [63:0] v1, input logic [63:0] v2,
                                   output bit ill, output logic [63:0] res);
    logic [6:0]  opc = in[6:0];
    logic [2:0]  f3 = in[14:12];
    logic [6:0]  f7 = in[31:25];
    logic [63:0] mask, a, b, sa, sb;
    int          sh;
    bit          is_op, alt;
    mask  = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    is_op = (opc == 7'h33);
    ill   = 0;
    if (opc != 7'h33 && opc != 7'h13) ill = 1;
    if (is_op && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) ill = 1;
    if (!is_op && f3 == 3'd1)
      if (xl == 32 ? (in[31:25] != 7'h00) : (in[31:26] != 6'h00)) ill = 1;
    if (!is_op && f3 == 3'd5)
      if (xl == 32 ? !(in[31:25] == 7'h00 || in[31:25] == 7'h20)
                   : !(in[31:26] == 6'h00 || in[31:26] == 6'h10)) ill = 1;
    if (int'(in[11:7]) >= nr || int'(in[19:15]) >= nr || (is_op && int'(in[24:20]) >= nr)) ill = 1;
    a   = v1 & mask;
    b   = (is_op ? v2 : {{52{in[31]}}, in[31:20]}) & mask;
    sa  = sx(a, xl);
    sb  = sx(b, xl);
    sh  = (xl == 64) ? int'(b[5:0]) : int'(b[4:0]);
    alt = is_op ? in[30] : (f3 == 3'd5 && in[30]);
    case (f3)
      3'd0: res = alt ? a - b : a + b;
      3'd1: res = a << sh;
      3'd2: res = ($signed(sa) < $signed(sb)) ? 64'd1 : 64'd0;
      3'd3: res = (a < b) ? 64'd1 : 64'd0;
      3'd4: res = a ^ b;
      3'd5: res = alt ? 64'($signed(sa) >>> sh) : (a >> sh);
      3'd6: res = a | b;
      default: res = a & b;
    endcase
    res = res & mask;
  endfunction

  // Apply one accepted instruction to both architectural models, queue expectations
  task automatic step(input logic [31:0] in);
    bit          ill;
    logic [63:0] res, v1, v2;
    logic [4:0]  rd = in[11:7];
    logic [4:0]  r1 = in[19:15];
    logic [4:0]  r2 = in[24:20];
    ref_exec(32, 32, in, rf32[r1], rf32[r2], ill, res);
    if (!ill && rd != 5'd0) rf32[rd] = res;
    q32.push_back('{ill, rd, (rd == 5'd0) ? 64'd0 : res, cyc});
    v1 = (r1 < 5'd16) ? rf64[r1[3:0]] : 64'd0;
    v2 = (r2 < 5'd16) ? rf64[r2[3:0]] : 64'd0;
    ref_exec(64, 16, in, v1, v2, ill, res);
    if (!ill && rd != 5'd0) rf64[rd[3:0]] = res;
    q64.push_back('{ill, rd, (rd == 5'd0) ? 64'd0 : res, cyc});
  endtask

  // Monitor: compare every presented pulse with the head of the scoreboard
  task automatic mon(input int w, input logic wv, input logic il, input logic [4:0] rd,
                     input logic [63:0] d, input logic [63:0] r);
    exp_t  e;
    string p = (w == 1) ? "x64" : "x32";
    if (wv || il) begin
      chk({p, "_excl"}, 64'(wv && il), 64'd0);
      if ((w == 0 && q32.size() == 0) || (w == 1 && q64.size() == 0)) begin
        total++;
        $display("FAIL %s_spurious: got wb_valid=%0b illegal=%0b expected no pulse", p, wv, il);
      end else begin
        e = (w == 1) ? q64.pop_front() : q32.pop_front();
        chk({p, "_latency"}, 64'(cyc), 64'(e.cyc + 32'd1));
        chk({p, "_illegal"}, 64'(il), 64'(e.ill));
        if (!e.ill) begin
          chk({p, "_wb_rd"}, 64'(rd), 64'(e.rd));
          chk({p, "_wb_data"}, d, e.data);
          if (w == 1) ret64 = (ret64 + 64'd1) & 64'hF;
          else        ret32 = (ret32 + 64'd1) & 64'hFFFF_FFFF;
        end
        chk({p, "_retired"}, r, (w == 1) ? ret64 : ret32);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, bus32.wb_valid, bus32.illegal, bus32.wb_rd, 64'(bus32.wb_data), 64'(bus32.retired));
      mon(1, bus64.wb_valid, bus64.illegal, bus64.wb_rd, bus64.wb_data, 64'(bus64.retired));
    end
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  // Present an instruction for one cycle; h=1 offers it under hold (not accepted)
  task automatic issue(input logic [31:0] in, input bit h);
    @(negedge clk);
    inst_r = in; valid_r = 1'b1; hold_r = h;
    #1;
    chk("x32_inst_ready", 64'(bus32.inst_ready), 64'(!h));
    chk("x64_inst_ready", 64'(bus64.inst_ready), 64'(!h));
    @(posedge clk);
    #1;
    if (!h) step(in);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_r = 1'b0; hold_r = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge: assert reset, forget everything in flight
  task automatic do_reset(input int n);
    rst = 1'b1;
    q32.delete(); q64.delete();
    foreach (rf32[i]) rf32[i] = 64'd0;
    foreach (rf64[i]) rf64[i] = 64'd0;
    ret32 = 64'd0; ret64 = 64'd0;
    valid_r = 1'b0; hold_r = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    #1;
    chk({tag, "_x32_wb_valid"}, 64'(bus32.wb_valid), 64'd0);
    chk({tag, "_x32_illegal"}, 64'(bus32.illegal), 64'd0);
    chk({tag, "_x32_wb_rd"}, 64'(bus32.wb_rd), 64'd0);
    chk({tag, "_x32_wb_data"}, 64'(bus32.wb_data), 64'd0);
    chk({tag, "_x32_retired"}, 64'(bus32.retired), 64'd0);
    chk({tag, "_x64_wb_valid"}, 64'(bus64.wb_valid), 64'd0);
    chk({tag, "_x64_illegal"}, 64'(bus64.illegal), 64'd0);
    chk({tag, "_x64_wb_data"}, bus64.wb_data, 64'd0);
    chk({tag, "_x64_retired"}, 64'(bus64.retired), 64'd0);
  endtask

  function automatic logic [4:0] rnd_reg();
    return ($urandom_range(0, 99) < 6) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
  endfunction

  function automatic logic [31:0] rnd_inst();
    int          k = $urandom_range(0, 99);
    logic [2:0]  f3 = 3'($urandom_range(0, 7));
    logic [6:0]  f7;
    logic [11:0] imm = 12'($urandom);
    int          s = $urandom_range(0, 3);
    if (k < 45) begin
      k = $urandom_range(0, 99);
      f7 = (k < 80) ? 7'h00 : (k < 95) ? 7'h20 : 7'($urandom);
      return enc_r(f7, rnd_reg(), rnd_reg(), f3, rnd_reg());
    end else if (k < 90) begin
      if (f3 == 3'd1 || f3 == 3'd5)
        imm[11:5] = (s == 0) ? 7'h00 : (s == 1) ? 7'h20 : (s == 2) ? 7'h01 : 7'($urandom);
      return enc_i(imm, rnd_reg(), f3, rnd_reg());
    end
    return {25'($urandom), 7'($urandom)};
  endfunction

  initial begin
    foreach (rf32[i]) rf32[i] = 64'd0;
    foreach (rf64[i]) rf64[i] = 64'd0;
    #1;
    do_reset(3);
    check_zero("reset");

    // ADDI x1,x0,5
    issue(enc_i(12'd5, 5'd0, 3'd0, 5'd1), 1'b0);
    idle(3);

    // Back-to-back dependents: ADDI x1,x0,-1; ADD x2,x1,x1; SUB x3,x2,x1
    issue(enc_i(12'hFFF, 5'd0, 3'd0, 5'd1), 1'b0);
    issue(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), 1'b0);
    issue(enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd3), 1'b0);
    idle(3);

    // x1 = 1 << 31, then SRAI/SRLI/SLT/SLTU
    issue(enc_i(12'd1, 5'd0, 3'd0, 5'd1), 1'b0);
    issue(enc_i(12'd31, 5'd1, 3'd1, 5'd1), 1'b0);
    issue(enc_i({7'h20, 5'd4}, 5'd1, 3'd5, 5'd2), 1'b0);
    issue(enc_i(12'd4, 5'd1, 3'd5, 5'd3), 1'b0);
    issue(enc_r(7'h00, 5'd0, 5'd1, 3'd2, 5'd4), 1'b0);
    issue(enc_r(7'h00, 5'd0, 5'd1, 3'd3, 5'd5), 1'b0);
    idle(3);

    // Load opcode and SLLI with imm[11:5]=0000001
    issue({12'd0, 5'd0, 3'd0, 5'd1, 7'b0000011}, 1'b0);
    issue(enc_i({7'h01, 5'd1}, 5'd1, 3'd1, 5'd1), 1'b0);
    issue(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd6), 1'b0);
    idle(3);

    // Hold for three cycles between two instructions
    issue(enc_i(12'd9, 5'd0, 3'd0, 5'd6), 1'b0);
    repeat (3) issue(enc_i(12'd3, 5'd6, 3'd0, 5'd7), 1'b1);
    issue(enc_i(12'd1, 5'd6, 3'd0, 5'd7), 1'b0);
    idle(3);

    // SLLI x1,x1,40 and rd=16 (legality differs between the two configurations)
    issue(enc_i(12'd40, 5'd1, 3'd1, 5'd1), 1'b0);
    issue(enc_i(12'd1, 5'd0, 3'd0, 5'd16), 1'b0);
    issue(enc_r(7'h00, 5'd0, 5'd1, 3'd0, 5'd0), 1'b0);
    idle(3);

    // Reset while an instruction is in EX
    issue(enc_i(12'd7, 5'd0, 3'd0, 5'd5), 1'b0);
    do_reset(2);
    check_zero("midrst");
    idle(4);

    // Randomized stream with holds and gaps
    for (int n = 0; n < 600; n++) begin
      int k = $urandom_range(0, 99);
      if (k < 10) idle(1);
      else issue(rnd_inst(), k < 28);
    end
    idle(5);
    chk("x32_drain", 64'(q32.size()), 64'd0);
    chk("x64_drain", 64'(q64.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
